powlib_busxbar: RTL
===================

POWLIB_BUSXBAR -- requirements
Module: powlib_busxbar

Interface
REQ-001 SHALL have parameter B_WRS, default 2: number of write (input) ports.
REQ-002 SHALL have parameter B_RDS, default 2: number of read (output) ports.
REQ-003 SHALL have parameter B_AW, default 32: address width.
REQ-004 SHALL have parameter B_DW, default 32: data width.
REQ-005 SHALL have parameter B_BASES, default {32'h1000,32'h0000}: packed base address per read port; slice j*B_AW+:B_AW belongs to port j.
REQ-006 SHALL have parameter B_SIZES, default {32'h0FFF,32'h0FFF}: packed inclusive region span per read port.
REQ-007 SHALL have parameter B_ARB, default 1: 0 = fixed priority, 1 = round-robin.
REQ-008 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-010 SHALL have port wrdatas, input, B_WRS*B_DW: write data; slice i belongs to writer i.
REQ-011 SHALL have port wraddrs, input, B_WRS*B_AW: write addresses.
REQ-012 SHALL have port wrvlds, input, B_WRS: write valids.
REQ-013 SHALL have port wrrdys, output, B_WRS: write readies.
REQ-014 SHALL have port rddatas, output, B_RDS*B_DW: read data.
REQ-015 SHALL have port rdaddrs, output, B_RDS*B_AW: forwarded address, unmodified.
REQ-016 SHALL have port rdvlds, output, B_RDS: read valids.
REQ-017 SHALL have port rdrdys, input, B_RDS: read readies.

Function
REQ-018 Writer i SHALL target read port j when BASE_j <= addr <= BASE_j+SIZE_j; on overlapping regions, the lowest j SHALL win.
REQ-019 Each read port SHALL own a one-entry output register with states EMPTY and FULL.
REQ-020 Port j SHALL be open when it is EMPTY, or when it is FULL and rdrdys[j]=1; an open port SHALL grant exactly one valid writer targeting it.
REQ-021 wrrdys[i] SHALL be combinational and SHALL be 1 only when wrvlds[i]=1 and writer i holds the grant; an ungranted writer SHALL hold its beat.
REQ-022 A granted beat SHALL appear on rddatas/rdaddrs with rdvlds=1 on the next edge; latency is 1 cycle.
REQ-023 FULL with rdrdy=1 and a new grant in the same cycle SHALL reload the register and keep rdvld=1, giving 1 beat/cycle per port.
REQ-024 FULL with rdrdy=0 SHALL hold data and address stable.
REQ-025 FULL with rdrdy=1 and no grant SHALL go EMPTY and drive rdvld=0.
REQ-026 With B_ARB=0, the lowest-index requesting writer SHALL win.
REQ-027 With B_ARB=1, each port SHALL keep a pointer, and the search SHALL start at the pointer; after a grant, the pointer SHALL become winner+1 modulo B_WRS.
REQ-028 A valid writer hitting no region SHALL get wrrdy=1 in the same cycle, and its beat SHALL be dropped.
REQ-029 Distinct writers targeting distinct ports SHALL all progress in the same cycle.

Reset
REQ-030 While rst=1, the block SHALL hold rdvlds=0, wrrdys=0, every state EMPTY and every round-robin pointer 0.
REQ-031 rddatas/rdaddrs SHALL reset to 0.
REQ-032 Reset asserted mid-transfer SHALL discard all held beats with no partial output.
REQ-033 The first grant SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-034 POWLIB_BUSXBAR_ERRCNT_EN defined SHALL add output port errcnt, 16 bits.
REQ-035 errcnt SHALL increment once per dropped unmapped beat, SHALL saturate at 16'hFFFF, and SHALL reset to 0.
REQ-036 Without POWLIB_BUSXBAR_ERRCNT_EN, the port and the counter SHALL be absent, and unmapped beats SHALL still be dropped silently.

Structure
REQ-037 Package powlib_bus_pkg SHALL hold the region-decode function, the constants ARB_FIXED=0 and ARB_RR=1, and the state encoding EMPTY/FULL.
REQ-038 Sub-module powlib_busxbar_arb SHALL implement the per-read-port B_WRS-way arbiter (fixed or round-robin), instantiated B_RDS times.

Verification
REQ-039 Writer0 sends 0x0010/data 0xA5 with rdrdy1=1 -> port0 rdvld=1 with data 0xA5 one cycle later; port1 stays idle.
REQ-040 Both writers continuously target 0x1004 with B_ARB=1 and rdrdy=1 -> port1 outputs alternate w0,w1,w0,w1 at one beat/cycle.
REQ-041 Same stimulus with B_ARB=0 -> only w0 beats appear; w1 wrrdy=0 throughout.
REQ-042 rdrdy0=0 for 5 cycles with port0 FULL -> data stable, writer stalled; rdrdy0=1 -> drains, next beat follows the cycle after.
REQ-043 Writer1 sends 0x3000 three times with ERRCNT_EN defined -> wrrdy1=1 each time, no rdvld, errcnt=3.
REQ-044 rst pulses while both ports are FULL -> rdvlds=0 immediately (asynchronous); after release, errcnt=0 and the pointers restart at writer0.

Source files
------------

// File: rtl/powlib_bus_pkg.sv
// ---------------------------------------------------------------------------
// powlib_bus_pkg
// Shared definitions for the powlib bus crossbar:
//   ARB_FIXED / ARB_RR : arbitration mode selectors for the B_ARB parameter
//   EMPTY / FULL       : encoding of each read port's one-entry output register
//   region_hit()       : inclusive base/span address decode used by the router
// Addresses up to 64 bits are supported by the decode helper.
// ---------------------------------------------------------------------------
package powlib_bus_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    // The upper bound is formed one bit wider so that a region reaching the
    // top of the address space does not wrap around and miss.
    function automatic logic region_hit(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input logic [63:0] size);
        logic [64:0] top;
        top = {1'b0, base} + {1'b0, size};
        return (addr >= base) && ({1'b0, addr} <= top);
    endfunction

endpackage

// File: rtl/powlib_busxbar_arb.sv
// ---------------------------------------------------------------------------
// powlib_busxbar_arb
// B_WRS-way arbiter owned by one read port of the crossbar.
//   clk, rst : clock and asynchronous active-high reset
//   reqs     : one request bit per writer targeting this port
//   open     : the port can accept a beat this cycle
//   grant    : one-hot grant, all zero when closed or nobody requests
// B_ARB = ARB_FIXED gives lowest-index priority; B_ARB = ARB_RR starts the
// search at a pointer that moves to winner+1 after every grant.
// ---------------------------------------------------------------------------
module powlib_busxbar_arb
    import powlib_bus_pkg::*;
#(
    parameter int B_WRS = 2,
    parameter int B_ARB = ARB_RR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [B_WRS-1:0] reqs,
    input  logic             open,
    output logic [B_WRS-1:0] grant
);

    localparam int PW = (B_WRS > 1) ? $clog2(B_WRS) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    int            start;
    int            idx;
    logic          found;

    // Walk the writers in search order and take the first requester.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        start = (B_ARB == ARB_RR) ? int'(ptr_q) : 0;
        for (int k = 0; k < B_WRS; k++) begin
            idx = (start + k) % B_WRS;
            for (int i = 0; i < B_WRS; i++) begin
                if (!found && open && reqs[i] && (i == idx)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    if (B_ARB == ARB_RR) begin
                        ptr_d = (i == B_WRS - 1) ? '0 : PW'(i + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/powlib_busxbar.sv
// ---------------------------------------------------------------------------
// powlib_busxbar
// Address-routed crossbar from B_WRS writers to B_RDS read ports. Each read
// port owns a one-entry output register (EMPTY/FULL) and an arbiter.
//   clk, rst          : clock and asynchronous active-high reset
//   wrdatas/wraddrs   : per-writer beat, slice i belongs to writer i
//   wrvlds / wrrdys   : per-writer handshake (wrrdys is combinational)
//   rddatas/rdaddrs   : per-port registered beat, address forwarded as is
//   rdvlds / rdrdys   : per-port handshake
//   errcnt            : saturating count of dropped unmapped beats, present
//                       only when POWLIB_BUSXBAR_ERRCNT_EN is defined
// Writers whose address hits no region are accepted immediately and their
// beat is discarded.
// ---------------------------------------------------------------------------
module powlib_busxbar
    import powlib_bus_pkg::*;
#(
    parameter int                      B_WRS   = 2,
    parameter int                      B_RDS   = 2,
    parameter int                      B_AW    = 32,
    parameter int                      B_DW    = 32,
    parameter logic [B_RDS*B_AW-1:0]   B_BASES = {32'h1000, 32'h0000},
    parameter logic [B_RDS*B_AW-1:0]   B_SIZES = {32'h0FFF, 32'h0FFF},
    parameter int                      B_ARB   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [B_WRS*B_DW-1:0]   wrdatas,
    input  logic [B_WRS*B_AW-1:0]   wraddrs,
    input  logic [B_WRS-1:0]        wrvlds,
    output logic [B_WRS-1:0]        wrrdys,
    output logic [B_RDS*B_DW-1:0]   rddatas,
    output logic [B_RDS*B_AW-1:0]   rdaddrs,
    output logic [B_RDS-1:0]        rdvlds,
    input  logic [B_RDS-1:0]        rdrdys
`ifdef POWLIB_BUSXBAR_ERRCNT_EN
    ,
    output logic [15:0]             errcnt
`endif
);

    logic [B_RDS-1:0]  tgt        [B_WRS];
    logic [B_WRS-1:0]  hit;
    logic [B_WRS-1:0]  port_reqs  [B_RDS];
    logic [B_WRS-1:0]  grants     [B_RDS];
    logic [B_RDS-1:0]  open;
    logic [B_WRS-1:0]  granted;

    logic [B_RDS-1:0]  state_q;
    logic [B_RDS-1:0]  state_d;
    logic [B_DW-1:0]   data_q     [B_RDS];
    logic [B_DW-1:0]   data_d     [B_RDS];
    logic [B_AW-1:0]   addr_q     [B_RDS];
    logic [B_AW-1:0]   addr_d     [B_RDS];

    // Region decode: the first (lowest-index) matching port wins overlaps.
    always_comb begin
        for (int i = 0; i < B_WRS; i++) begin
            tgt[i] = '0;
            hit[i] = 1'b0;
            for (int j = 0; j < B_RDS; j++) begin
                if (!hit[i] && region_hit(64'(wraddrs[i*B_AW +: B_AW]),
                                          64'(B_BASES[j*B_AW +: B_AW]),
                                          64'(B_SIZES[j*B_AW +: B_AW]))) begin
                    tgt[i][j] = 1'b1;
                    hit[i]    = 1'b1;
                end
            end
        end
    end

    // A port can take a beat when empty, or when full and being drained.
    always_comb begin
        for (int j = 0; j < B_RDS; j++) begin
            open[j] = (state_q[j] == EMPTY) || rdrdys[j];
            for (int i = 0; i < B_WRS; i++) begin
                port_reqs[j][i] = wrvlds[i] & tgt[i][j];
            end
        end
    end

    for (genvar gj = 0; gj < B_RDS; gj++) begin : g_arb
        powlib_busxbar_arb #(
            .B_WRS (B_WRS),
            .B_ARB (B_ARB)
        ) u_arb (
            .clk   (clk),
            .rst   (rst),
            .reqs  (port_reqs[gj]),
            .open  (open[gj]),
            .grant (grants[gj])
        );
    end

    // Unmapped writers are accepted so their beat is consumed and dropped.
    always_comb begin
        granted = '0;
        for (int j = 0; j < B_RDS; j++) begin
            granted = granted | grants[j];
        end
        wrrdys = wrvlds & (granted | ~hit) & {B_WRS{~rst}};
    end

    // A grant always loads (even while draining); otherwise a drain empties.
    always_comb begin
        for (int j = 0; j < B_RDS; j++) begin
            state_d[j] = state_q[j];
            data_d[j]  = data_q[j];
            addr_d[j]  = addr_q[j];
            if (|grants[j]) begin
                state_d[j] = FULL;
                for (int i = 0; i < B_WRS; i++) begin
                    if (grants[j][i]) begin
                        data_d[j] = wrdatas[i*B_DW +: B_DW];
                        addr_d[j] = wraddrs[i*B_AW +: B_AW];
                    end
                end
            end else if (rdrdys[j]) begin
                state_d[j] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= {B_RDS{EMPTY}};
            for (int j = 0; j < B_RDS; j++) begin
                data_q[j] <= '0;
                addr_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int j = 0; j < B_RDS; j++) begin
                data_q[j] <= data_d[j];
                addr_q[j] <= addr_d[j];
            end
        end
    end

    always_comb begin
        rddatas = '0;
        rdaddrs = '0;
        rdvlds  = '0;
        for (int j = 0; j < B_RDS; j++) begin
            rddatas[j*B_DW +: B_DW] = data_q[j];
            rdaddrs[j*B_AW +: B_AW] = addr_q[j];
            rdvlds[j]               = (state_q[j] == FULL);
        end
    end

`ifdef POWLIB_BUSXBAR_ERRCNT_EN
    logic [15:0] errcnt_q;
    logic [15:0] errcnt_d;
    logic [16:0] errsum;
    int          drops;

    // Several writers may miss in one cycle; each miss counts once.
    always_comb begin
        drops = 0;
        for (int i = 0; i < B_WRS; i++) begin
            if (wrvlds[i] && !hit[i]) begin
                drops = drops + 1;
            end
        end
        errsum   = {1'b0, errcnt_q} + 17'(drops);
        errcnt_d = errsum[16] ? 16'hFFFF : errsum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign errcnt = errcnt_q;
`endif

endmodule
